inst_loader: RTL
================

# inst_loader

Serial boot loader that writes a program image into instruction memory before the pipelined core starts fetching. It receives a UART byte stream (8N1), assembles little-endian 32-bit instruction words, and issues one-cycle write strobes to the instruction memory write port at consecutive word addresses. It holds the core in reset until the image is complete, then releases it and goes idle.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- MAX_WORDS, 256, largest accepted image in 32-bit words; must be ≤ 65535.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  UART serial line, idle high, asynchronous to clk.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  32  byte address of the word being written (word index × 4).
- mem_wdata  output  32  instruction word being written.
- cpu_hold  output  1  high while loading; core PC and pipeline held in reset.
- done  output  1  sticky; image fully written.
- error  output  1  sticky until rst; framing error or oversize header seen.

## Operation
- **rx sync:** two-flop synchronizer; all logic uses the synchronized value.
- **Byte receiver states:**
  - IDLE → START on synchronized rx = 0.
  - START: wait CLKS_PER_BIT/2 cycles, sample rx. rx = 0 → DATA; rx = 1 → IDLE (glitch, no error).
  - DATA: 8 samples, each CLKS_PER_BIT cycles apart, LSB first.
  - STOP: one more sample after CLKS_PER_BIT cycles. rx = 1 → byte valid for 1 cycle, then IDLE. rx = 0 → framing error: byte discarded, error = 1, then IDLE once rx returns high.
- **Frame format:**
  - Header: 2 bytes, word count N, low byte first.
  - Payload: N × 4 bytes, each word least-significant byte first.
- **Loader states:**
  - HDR_LO → HDR_HI: capture the header bytes.
  - After HDR_HI:
    - N = 0 → DONE.
    - N > MAX_WORDS → error = 1, return to HDR_LO.
    - Otherwise → LOAD.
  - LOAD: shift bytes into a 32-bit assembly register, byte k goes to bits [8k+7:8k], with a 2-bit byte counter. On the 4th byte:
    - Present the word on mem_wdata.
    - mem_addr = idx × 4.
    - Pulse mem_we.
    - Increment idx.
  - After the write of word N−1 → DONE.
  - DONE: done = 1, cpu_hold = 0. All further rx traffic is ignored until rst.
- **Framing error mid-load:** discard the partial word and the whole image. Set error = 1, reset idx and the byte counter, return to HDR_LO. Words already written stay in memory and are overwritten by the next image.
- **Address rules:** idx is 16 bits; mem_addr = {14'b0, idx, 2'b00}. Addresses never wrap because idx < MAX_WORDS.

## Timing
- **Reset values:** mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_hold = 1, done = 0, error = 0. Loader in HDR_LO, receiver in IDLE, idx = 0.
- **Reset mid-operation:** abandons any byte or word immediately. Memory contents are undefined.
- **Byte latency:** byte valid occurs 2 (sync) + CLKS_PER_BIT/2 + 9×CLKS_PER_BIT cycles after the start-bit falling edge reaches the rx pin.
- **Word write:** mem_we is high exactly one cycle, the cycle after the 4th byte valid. mem_addr and mem_wdata are registered and stable in that cycle. Both hold their values afterwards; mem_we = 0 otherwise.
- **Release:**
  - cpu_hold falls and done rises together, one cycle after the final mem_we cycle, so the memory write completes before the first fetch.
  - For N = 0, cpu_hold falls and done rises one cycle after the header high byte valid.
- **error:** rises the cycle after the failing stop-bit sample or the oversize header. It does not affect cpu_hold.
- **Back-to-back bytes:** no idle time is required between a stop bit and the next start bit.

## Test plan
Benches run with CLKS_PER_BIT = 4, MAX_WORDS = 4.
- **Reset check:** assert rst mid-frame → all outputs at reset values that same cycle. Release rst → cpu_hold = 1, done = 0.
- **Normal image:** send header 02 00, then 13 05 10 00, EF 00 00 00 → mem_we pulses twice:
  - mem_addr = 0x0, mem_wdata = 0x00100513.
  - mem_addr = 0x4, mem_wdata = 0x000000EF.
  - Next cycle: done = 1, cpu_hold = 0. Further bytes produce no mem_we.
- **Empty image:** header 00 00 → no mem_we; done = 1, cpu_hold = 0 one cycle after the second byte.
- **Oversize header:** header 05 00 → error = 1, no mem_we. Then send 01 00, 78 56 34 12 → one write of 0x12345678 at 0x0, done = 1, error still 1.
- **Framing error mid-load:** header 01 00, byte AA, then a byte with stop bit 0 → error = 1, no mem_we, cpu_hold = 1. Then send 01 00, DD CC BB AA → write 0xAABBCCDD at 0x0, done = 1.
- **Glitch rejection:** rx low pulse of 1 cycle in IDLE → no byte, error = 0. The next valid image loads correctly.

Source files
------------

// File: rtl/inst_loader.sv
// inst_loader: UART 8N1 boot loader that writes a little-endian word image into
// instruction memory and holds the core in reset until the image is complete.
module inst_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_WORDS    = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    typedef enum logic [2:0] {LD_HDR_LO, LD_HDR_HI, LD_LOAD, LD_LAST, LD_DONE} ld_state_t;

    rx_state_t rx_state, rx_next;
    ld_state_t ld_state, ld_next;

    logic          rx_meta, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    shreg;
    logic          byte_valid;
    logic          tick, frame_err;
    logic [7:0]    hdr_lo;
    logic [15:0]   hdr, n_words, idx;
    logic [1:0]    bcnt;
    logic [23:0]   asm_reg;
    logic          wr, oversize, abort, last_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick      = (rx_state == RX_START) ? (cnt == HALF) : (cnt == FULL);
    assign frame_err = rx_state == RX_STOP && tick && !rx_s;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_s) rx_next = RX_START;
            RX_START: if (tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bitn == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (tick) rx_next = rx_s ? RX_IDLE : RX_BREAK;
            default:  if (rx_s) rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bitn       <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
        end else begin
            rx_state   <= rx_next;
            cnt        <= (rx_state == RX_IDLE || tick) ? '0 : cnt + 1'b1;
            bitn       <= (rx_state == RX_START) ? 3'd0 : (rx_state == RX_DATA && tick) ? bitn + 3'd1 : bitn;
            shreg      <= (rx_state == RX_DATA && tick) ? {rx_s, shreg[7:1]} : shreg;
            byte_valid <= rx_state == RX_STOP && tick && rx_s;
        end
    end

    assign hdr       = {shreg, hdr_lo};
    assign oversize  = ld_state == LD_HDR_HI && byte_valid && hdr > 16'(MAX_WORDS);
    assign wr        = ld_state == LD_LOAD && byte_valid && bcnt == 2'd3;
    assign last_word = idx + 16'd1 == n_words;
    // Once the last word is committed, line traffic can no longer disturb the image.
    assign abort     = frame_err && (ld_state == LD_HDR_LO || ld_state == LD_HDR_HI || ld_state == LD_LOAD);

    always_comb begin
        ld_next = ld_state;
        case (ld_state)
            LD_HDR_LO: if (byte_valid) ld_next = LD_HDR_HI;
            LD_HDR_HI: if (byte_valid) ld_next = (hdr == 16'd0) ? LD_DONE : oversize ? LD_HDR_LO : LD_LOAD;
            LD_LOAD:   if (wr && last_word) ld_next = LD_LAST;
            default:   ld_next = LD_DONE;
        endcase
        if (abort) ld_next = LD_HDR_LO;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_state  <= LD_HDR_LO;
            hdr_lo    <= '0;
            n_words   <= '0;
            idx       <= '0;
            bcnt      <= '0;
            asm_reg   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            error     <= 1'b0;
        end else begin
            ld_state  <= ld_next;
            hdr_lo    <= (ld_state == LD_HDR_LO && byte_valid) ? shreg : hdr_lo;
            n_words   <= (ld_state == LD_HDR_HI && byte_valid) ? hdr : n_words;
            idx       <= (abort || ld_state == LD_HDR_LO) ? 16'd0 : wr ? idx + 16'd1 : idx;
            bcnt      <= (abort || ld_state != LD_LOAD) ? 2'd0 : byte_valid ? bcnt + 2'd1 : bcnt;
            asm_reg   <= (ld_state == LD_LOAD && byte_valid) ? {shreg, asm_reg[23:8]} : asm_reg;
            mem_we    <= wr;
            mem_addr  <= wr ? {14'b0, idx, 2'b00} : mem_addr;
            mem_wdata <= wr ? {shreg, asm_reg} : mem_wdata;
            error     <= error | abort | oversize;
        end
    end

    assign cpu_hold = ld_state != LD_DONE;
    assign done     = ld_state == LD_DONE;
endmodule
